mem_issue_queue: RTL and testbench

In-order issue queue for load/store micro-ops, feeding the memory execution stage. It sits between rename/dispatch and the memory unit.
- Buffers dispatched memory ops in a circular FIFO.
- Tracks branch masks and kills mispredicted entries.
- Issues at most one op per cycle as a registered packed bundle with a valid bit.
- The bundle format is exactly the one the memory execution stage unpacks.

---
 rtl/mem_issue_queue.sv | 124 ++++++++++++
 tb/tb_mem_issue_queue.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue.sv
// In-order load/store issue queue: circular buffer of dispatched memory ops with
// branch-mask tracking, mispredict kill (entries become holes), single registered issue.
module mem_issue_queue #(
    parameter int WIDTH_BRM = 4,
    parameter int WIDTH_REG = 5,
    parameter int DEPTH_LOG = 3,
    parameter int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 18
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [6:0]             i_uop,
    input  logic [9:0]             i_func,
    input  logic [WIDTH_REG-1:0]   i_rd,
    input  logic [WIDTH_BRM-1:0]   i_brmask,
    input  logic [31:0]            i_pc,
    input  logic [31:0]            i_imm,
    input  logic [31:0]            i_op1,
    input  logic [31:0]            i_op2,
    input  logic                   i_br_valid,
    input  logic [WIDTH_BRM-1:0]   i_br_tag,
    input  logic                   i_br_mispred,
    input  logic                   i_stall,
    output logic [WIDTH-1:0]       o_instr,
    output logic [DEPTH_LOG:0]     o_count,
    output logic                   o_empty
);

    localparam int DEPTH = 2**DEPTH_LOG;

    typedef struct packed {
        logic [6:0]           uop;
        logic [WIDTH_REG-1:0] rd;
        logic [31:0]          pc;
        logic [9:0]           func;
        logic [31:0]          imm;
        logic [31:0]          op2;
        logic [31:0]          op1;
    } payload_t;

    payload_t               payload [DEPTH];
    logic [WIDTH_BRM-1:0]   brmask  [DEPTH];
    logic [DEPTH-1:0]       live;
    logic [DEPTH_LOG-1:0]   head;
    logic [DEPTH_LOG-1:0]   tail;
    logic [DEPTH_LOG:0]     count;

    logic                   br_kill;
    logic [WIDTH_BRM-1:0]   br_clear;
    logic                   has_head;
    logic                   head_live;
    logic                   head_kill;
    logic                   pop;
    logic                   issue;
    logic                   enq_drop;
    logic                   enq;
    payload_t               head_pl;

    assign br_kill   = i_br_valid && i_br_mispred;
    assign br_clear  = (i_br_valid && !i_br_mispred) ? i_br_tag : '0;

    assign has_head  = (count != '0);
    assign head_live = live[head];
    assign head_kill = br_kill && (|(brmask[head] & i_br_tag));
    assign head_pl   = payload[head];

    // A killed live head leaves this edge as a hole, so it pops regardless of stall.
    assign pop       = has_head && (!head_live || head_kill || !i_stall);
    assign issue     = has_head && head_live && !head_kill && !i_stall;

    assign o_ready   = (count != (DEPTH_LOG+1)'(DEPTH));
    assign enq_drop  = br_kill && (|(i_brmask & i_br_tag));
    assign enq       = i_valid && o_ready && !enq_drop;

    assign o_count   = count;
    assign o_empty   = (count == '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            live    <= '0;
            o_instr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                brmask[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (br_kill && (|(brmask[i] & i_br_tag))) begin
                    live[i] <= 1'b0;
                end
                brmask[i] <= brmask[i] & ~br_clear;
            end
            if (pop) begin
                live[head] <= 1'b0;
                head       <= head + DEPTH_LOG'(1);
            end
            // Tail slot is always free when enq is set, so it never collides with head.
            if (enq) begin
                live[tail]   <= 1'b1;
                brmask[tail] <= i_brmask & ~br_clear;
                tail         <= tail + DEPTH_LOG'(1);
            end
            count <= count + (DEPTH_LOG+1)'(enq) - (DEPTH_LOG+1)'(pop);

            o_instr[WIDTH-1] <= issue;
            if (issue) begin
                o_instr[WIDTH-2:0] <= {head_pl.uop, brmask[head] & ~br_clear, head_pl.rd,
                                       head_pl.pc, head_pl.func, head_pl.imm,
                                       head_pl.op2, head_pl.op1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) begin
            payload[tail] <= '{uop: i_uop, rd: i_rd, pc: i_pc, func: i_func,
                               imm: i_imm, op2: i_op2, op1: i_op1};
        end
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue: reset, latency, fill/wrap, kill holes,
// branch-mask clearing, simultaneous enq/issue and mid-operation reset.
module tb_mem_issue_queue;

    localparam int WIDTH_BRM = 4;
    localparam int WIDTH_REG = 5;
    localparam int DEPTH_LOG = 3;
    localparam int WIDTH     = 4*32 + WIDTH_REG + WIDTH_BRM + 18;

    logic                 i_clk = 1'b0;
    logic                 i_rst = 1'b1;
    logic                 i_valid = 1'b0;
    logic                 o_ready;
    logic [6:0]           i_uop = '0;
    logic [9:0]           i_func = '0;
    logic [WIDTH_REG-1:0] i_rd = '0;
    logic [WIDTH_BRM-1:0] i_brmask = '0;
    logic [31:0]          i_pc = '0;
    logic [31:0]          i_imm = '0;
    logic [31:0]          i_op1 = '0;
    logic [31:0]          i_op2 = '0;
    logic                 i_br_valid = 1'b0;
    logic [WIDTH_BRM-1:0] i_br_tag = '0;
    logic                 i_br_mispred = 1'b0;
    logic                 i_stall = 1'b0;
    logic [WIDTH-1:0]     o_instr;
    logic [DEPTH_LOG:0]   o_count;
    logic                 o_empty;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 i_clk = ~i_clk;

    mem_issue_queue #(
        .WIDTH_BRM(WIDTH_BRM), .WIDTH_REG(WIDTH_REG), .DEPTH_LOG(DEPTH_LOG), .WIDTH(WIDTH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_uop(i_uop), .i_func(i_func), .i_rd(i_rd), .i_brmask(i_brmask),
        .i_pc(i_pc), .i_imm(i_imm), .i_op1(i_op1), .i_op2(i_op2),
        .i_br_valid(i_br_valid), .i_br_tag(i_br_tag), .i_br_mispred(i_br_mispred),
        .i_stall(i_stall), .o_instr(o_instr), .o_count(o_count), .o_empty(o_empty)
    );

    // Bundle fields, MSB to LSB: val, uop, brmask, rd, pc, func, imm, op2, op1
    wire        f_val    = o_instr[154];
    wire [6:0]  f_uop    = o_instr[153:147];
    wire [3:0]  f_brmask = o_instr[146:143];
    wire [4:0]  f_rd     = o_instr[142:138];
    wire [31:0] f_pc     = o_instr[137:106];
    wire [9:0]  f_func   = o_instr[105:96];
    wire [31:0] f_imm    = o_instr[95:64];
    wire [31:0] f_op2    = o_instr[63:32];
    wire [31:0] f_op1    = o_instr[31:0];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] uop, input logic [4:0] rd, input logic [3:0] brm,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] op1);
        i_valid  = 1'b1;
        i_uop    = uop;
        i_func   = 10'd2;
        i_rd     = rd;
        i_brmask = brm;
        i_pc     = pc;
        i_imm    = imm;
        i_op1    = op1;
        i_op2    = op1 ^ 32'hA5A5_0000;
    endtask

    task automatic idle();
        i_valid      = 1'b0;
        i_br_valid   = 1'b0;
        i_br_mispred = 1'b0;
        i_br_tag     = '0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++; if (o_instr !== '0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", o_instr); end
        n_tests++; if (o_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
        n_tests++; if (o_ready !== 1'b1 || o_empty !== 1'b1) begin n_fail++; $display("FAIL reset_flags: got ready %b empty %b want 1 1", o_ready, o_empty); end
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        n_tests++; if (o_count !== 4'd0 || o_ready !== 1'b1 || f_val !== 1'b0) begin n_fail++; $display("FAIL post_reset: got count %0d ready %b val %b want 0 1 0", o_count, o_ready, f_val); end
    endtask

    task automatic test_single_load();
        i_stall = 1'b0;
        drive(7'b0000011, 5'd3, 4'b0000, 32'h0000_1000, 32'd4, 32'h100);
        tick();
        idle();
        n_tests++; if (o_count !== 4'd1 || f_val !== 1'b0) begin n_fail++; $display("FAIL single_enq: got count %0d val %b want 1 0", o_count, f_val); end
        tick();
        n_tests++; if (f_val !== 1'b1 || f_uop !== 7'b0000011 || f_rd !== 5'd3 || f_func !== 10'd2) begin n_fail++; $display("FAIL single_issue_ctl: got val %b uop %b rd %0d func %0d want 1 0000011 3 2", f_val, f_uop, f_rd, f_func); end
        n_tests++; if (f_op1 !== 32'h100 || f_imm !== 32'd4 || f_pc !== 32'h1000 || f_op2 !== 32'hA5A5_0100) begin n_fail++; $display("FAIL single_issue_data: got op1 %h imm %h pc %h op2 %h", f_op1, f_imm, f_pc, f_op2); end
        n_tests++; if (o_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", o_empty); end
        tick();
        n_tests++; if (f_val !== 1'b0 || f_op1 !== 32'h100) begin n_fail++; $display("FAIL single_hold: got val %b op1 %h want 0 100", f_val, f_op1); end
    endtask

    task automatic test_fill_wrap();
        i_stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(7'b0100011, 5'(k), 4'b0000, 32'h2000 + 32'(4*k), 32'd0, 32'h300 + 32'(k));
            tick();
        end
        n_tests++; if (o_count !== 4'd8 || o_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got count %0d ready %b want 8 0", o_count, o_ready); end
        drive(7'b0100011, 5'd31, 4'b0000, 32'h9999, 32'd0, 32'h0);
        tick();
        n_tests++; if (o_count !== 4'd8 || f_val !== 1'b0) begin n_fail++; $display("FAIL fill_ninth: got count %0d val %b want 8 0", o_count, f_val); end
        idle();
        i_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_tests++; if (f_val !== 1'b1 || f_rd !== 5'(k) || f_pc !== 32'h2000 + 32'(4*k)) begin n_fail++; $display("FAIL drain_%0d: got val %b rd %0d pc %h want 1 %0d %h", k, f_val, f_rd, f_pc, k, 32'h2000 + 32'(4*k)); end
            if (k == 0) begin
                n_tests++; if (o_ready !== 1'b1 || o_count !== 4'd7) begin n_fail++; $display("FAIL drain_ready: got ready %b count %0d want 1 7", o_ready, o_count); end
            end
        end
        tick();
        n_tests++; if (f_val !== 1'b0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL drain_done: got val %b empty %b want 0 1", f_val, o_empty); end
    endtask

    task automatic test_kill();
        i_stall = 1'b1;
        drive(7'b0000011, 5'd10, 4'b0001, 32'h4000, 32'd0, 32'h10); tick();
        drive(7'b0000011, 5'd11, 4'b0000, 32'h4004, 32'd0, 32'h11); tick();
        drive(7'b0000011, 5'd12, 4'b0001, 32'h4008, 32'd0, 32'h12); tick();
        idle();
        i_stall      = 1'b0;
        i_br_valid   = 1'b1;
        i_br_tag     = 4'b0001;
        i_br_mispred = 1'b1;
        tick();
        idle();
        n_tests++; if (f_val !== 1'b0 || o_count !== 4'd2) begin n_fail++; $display("FAIL kill_hole0: got val %b count %0d want 0 2", f_val, o_count); end
        tick();
        n_tests++; if (f_val !== 1'b1 || f_rd !== 5'd11 || o_count !== 4'd1) begin n_fail++; $display("FAIL kill_live: got val %b rd %0d count %0d want 1 11 1", f_val, f_rd, o_count); end
        tick();
        n_tests++; if (f_val !== 1'b0 || o_count !== 4'd0) begin n_fail++; $display("FAIL kill_hole2: got val %b count %0d want 0 0", f_val, o_count); end
    endtask

    task automatic test_brmask_resolve();
        i_stall = 1'b1;
        drive(7'b0000011, 5'd5, 4'b0011, 32'h5000, 32'd0, 32'h50); tick();
        drive(7'b0000011, 5'd6, 4'b0100, 32'h5004, 32'd0, 32'h51);
        i_br_valid = 1'b1; i_br_tag = 4'b0100; i_br_mispred = 1'b0;
        tick();
        drive(7'b0000011, 5'd7, 4'b1000, 32'h5008, 32'd0, 32'h52);
        i_br_tag = 4'b0001;
        tick();
        idle();
        i_stall = 1'b0;
        tick();
        n_tests++; if (f_val !== 1'b1 || f_rd !== 5'd5 || f_brmask !== 4'b0010) begin n_fail++; $display("FAIL brm_stored: got val %b rd %0d brmask %b want 1 5 0010", f_val, f_rd, f_brmask); end
        tick();
        n_tests++; if (f_val !== 1'b1 || f_rd !== 5'd6 || f_brmask !== 4'b0000) begin n_fail++; $display("FAIL brm_enq: got val %b rd %0d brmask %b want 1 6 0000", f_val, f_rd, f_brmask); end
        i_br_valid = 1'b1; i_br_tag = 4'b1000; i_br_mispred = 1'b0;
        tick();
        idle();
        n_tests++; if (f_val !== 1'b1 || f_rd !== 5'd7 || f_brmask !== 4'b0000) begin n_fail++; $display("FAIL brm_issue: got val %b rd %0d brmask %b want 1 7 0000", f_val, f_rd, f_brmask); end
    endtask

    task automatic test_back_to_back();
        i_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(7'b0100011, 5'(20 + k), 4'b0000, 32'h6000 + 32'(4*k), 32'd8, 32'h60 + 32'(k));
            tick();
        end
        n_tests++; if (o_count !== 4'd4) begin n_fail++; $display("FAIL b2b_fill: got count %0d want 4", o_count); end
        i_stall = 1'b0;
        drive(7'b0100011, 5'd24, 4'b0000, 32'h6010, 32'd8, 32'h64);
        tick();
        n_tests++; if (o_count !== 4'd4 || f_val !== 1'b1 || f_rd !== 5'd20) begin n_fail++; $display("FAIL b2b_same: got count %0d val %b rd %0d want 4 1 20", o_count, f_val, f_rd); end
        drive(7'b0100011, 5'd25, 4'b0010, 32'h6014, 32'd8, 32'h65);
        i_br_valid = 1'b1; i_br_tag = 4'b0010; i_br_mispred = 1'b1;
        tick();
        idle();
        n_tests++; if (o_count !== 4'd3 || f_val !== 1'b1 || f_rd !== 5'd21) begin n_fail++; $display("FAIL b2b_drop: got count %0d val %b rd %0d want 3 1 21", o_count, f_val, f_rd); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (f_val !== 1'b1 || f_rd !== 5'(22 + k)) begin n_fail++; $display("FAIL b2b_drain_%0d: got val %b rd %0d want 1 %0d", k, f_val, f_rd, 22 + k); end
        end
        tick();
        n_tests++; if (f_val !== 1'b0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_end: got val %b empty %b want 0 1", f_val, o_empty); end
    endtask

    task automatic test_reset_mid();
        i_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(7'b0000011, 5'(k + 1), 4'b0000, 32'h7000 + 32'(4*k), 32'd0, 32'h70);
            tick();
        end
        idle();
        n_tests++; if (o_count !== 4'd5 || o_ready !== 1'b1) begin n_fail++; $display("FAIL mid_fill: got count %0d ready %b want 5 1", o_count, o_ready); end
        #2;
        i_rst = 1'b1;
        #1;
        n_tests++; if (o_instr !== '0 || o_count !== 4'd0 || o_ready !== 1'b1 || o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got instr %h count %0d ready %b empty %b want 0 0 1 1", o_instr, o_count, o_ready, o_empty); end
        tick();
        i_rst   = 1'b0;
        i_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++; if (f_val !== 1'b0 || o_empty !== 1'b1) begin n_fail++; $display("FAIL mid_after_%0d: got val %b empty %b want 0 1", k, f_val, o_empty); end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_fill_wrap();
        test_kill();
        test_brmask_resolve();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
